// File: rtl/verisc_pkg.sv
// Shared encodings for the VeriRISC sequencer/controller: opcodes, phases,
// run states and the decode-group helpers used by both controller files.
package verisc_pkg;

    localparam logic [2:0] HLT = 3'd0;
    localparam logic [2:0] SKZ = 3'd1;
    localparam logic [2:0] ADD = 3'd2;
    localparam logic [2:0] AND = 3'd3;
    localparam logic [2:0] XOR = 3'd4;
    localparam logic [2:0] LDA = 3'd5;
    localparam logic [2:0] STO = 3'd6;
    localparam logic [2:0] JMP = 3'd7;

    localparam logic [2:0] INST_ADDR  = 3'd0;
    localparam logic [2:0] INST_FETCH = 3'd1;
    localparam logic [2:0] INST_LOAD  = 3'd2;
    localparam logic [2:0] IDLE       = 3'd3;
    localparam logic [2:0] OP_ADDR    = 3'd4;
    localparam logic [2:0] OP_FETCH   = 3'd5;
    localparam logic [2:0] ALU_OP     = 3'd6;
    localparam logic [2:0] STORE      = 3'd7;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HALTED = 2'd1,
        ERROR  = 2'd2
    } run_state_t;

    // Instructions that read an operand from memory into the accumulator.
    function automatic logic is_aluop(input logic [2:0] op);
        return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
    endfunction

    // Phases in which the memory bus may insert wait-states.
    function automatic logic is_wait_phase(input logic [2:0] ph, input logic [2:0] op);
        return (ph == INST_FETCH) ||
               ((ph == OP_FETCH) && is_aluop(op)) ||
               ((ph == STORE) && (op == STO));
    endfunction

endpackage

// File: rtl/verisc_decode.sv
// Purely combinational phase/opcode to datapath-strobe table. All strobes are
// forced low unless the controller is in its RUN state.
module verisc_decode
    import verisc_pkg::*;
(
    input  logic       run,
    input  logic [2:0] phase,
    input  logic [2:0] opcode,
    input  logic       zero,
    output logic       sel,
    output logic       rd,
    output logic       ld_ir,
    output logic       halt,
    output logic       inc_pc,
    output logic       ld_ac,
    output logic       ld_pc,
    output logic       wr,
    output logic       data_e
);

    logic aluop;
    logic op_halt;
    logic op_skz;
    logic op_sto;
    logic op_jmp;

    assign aluop   = is_aluop(opcode);
    assign op_halt = (opcode == HLT);
    assign op_skz  = (opcode == SKZ);
    assign op_sto  = (opcode == STO);
    assign op_jmp  = (opcode == JMP);

    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        ld_ir  = 1'b0;
        halt   = 1'b0;
        inc_pc = 1'b0;
        ld_ac  = 1'b0;
        ld_pc  = 1'b0;
        wr     = 1'b0;
        data_e = 1'b0;
        if (run) begin
            case (phase)
                INST_ADDR: begin
                    sel = 1'b1;
                end
                INST_FETCH: begin
                    sel = 1'b1;
                    rd  = 1'b1;
                end
                INST_LOAD, IDLE: begin
                    sel   = 1'b1;
                    rd    = 1'b1;
                    ld_ir = 1'b1;
                end
                OP_ADDR: begin
                    inc_pc = 1'b1;
                    halt   = op_halt;
                end
                OP_FETCH: begin
                    rd = aluop;
                end
                ALU_OP: begin
                    rd     = aluop;
                    // zero only matters here, for the skip decision
                    inc_pc = op_skz & zero;
                    ld_pc  = op_jmp;
                    data_e = op_sto;
                end
                default: begin
                    rd     = aluop;
                    ld_ac  = aluop;
                    ld_pc  = op_jmp;
                    wr     = op_sto;
                    data_e = op_sto;
                end
            endcase
        end
    end

endmodule

// File: rtl/verisc_seq_ctrl.sv
// VeriRISC controller with built-in 8-phase sequencer, memory wait-states,
// wait timeout (sticky bus_err) and HALTED state. Optional single-step mode
// is enabled by defining VERISC_SEQ_CTRL_STEP_EN (adds the step_mode input).
module verisc_seq_ctrl
    import verisc_pkg::*;
#(
    parameter int WAIT_TMO = 15,
    parameter int TMO_W    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    input  logic       resume,
`ifdef VERISC_SEQ_CTRL_STEP_EN
    input  logic       step_mode,
`endif
    output logic       sel,
    output logic       rd,
    output logic       ld_ir,
    output logic       halt,
    output logic       inc_pc,
    output logic       ld_ac,
    output logic       ld_pc,
    output logic       wr,
    output logic       data_e,
    output logic [2:0] phase,
    output logic       halted,
    output logic       bus_err,
    output logic       stall
);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(WAIT_TMO - 1);

    run_state_t       state_reg, state_next;
    logic [2:0]       phase_reg, phase_next;
    logic [TMO_W-1:0] wcnt_reg, wcnt_next;
    logic             stall_next;
    logic             step_stop;

`ifdef VERISC_SEQ_CTRL_STEP_EN
    assign step_stop = step_mode;
`else
    assign step_stop = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= RUN;
            phase_reg <= INST_ADDR;
            wcnt_reg  <= '0;
        end else begin
            state_reg <= state_next;
            phase_reg <= phase_next;
            wcnt_reg  <= wcnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        phase_next = phase_reg;
        wcnt_next  = wcnt_reg;
        stall_next = 1'b0;
        case (state_reg)
            RUN: begin
                if (is_wait_phase(phase_reg, opcode) && !mem_ready) begin
                    stall_next = 1'b1;
                    // mem_ready has priority: the timeout only fires on a cycle that is really stalled
                    if (wcnt_reg == TMO_LAST) begin
                        state_next = ERROR;
                    end else begin
                        wcnt_next = wcnt_reg + TMO_W'(1);
                    end
                end else begin
                    wcnt_next = '0;
                    if ((phase_reg == OP_ADDR) && (opcode == HLT)) begin
                        state_next = HALTED;
                        phase_next = INST_ADDR;
                    end else if ((phase_reg == STORE) && step_stop) begin
                        state_next = HALTED;
                        phase_next = INST_ADDR;
                    end else begin
                        phase_next = phase_reg + 3'd1;
                    end
                end
            end
            HALTED: begin
                phase_next = INST_ADDR;
                wcnt_next  = '0;
                if (resume) begin
                    state_next = RUN;
                end
            end
            ERROR: begin
                // frozen until reset
            end
            default: begin
                state_next = RUN;
                phase_next = INST_ADDR;
                wcnt_next  = '0;
            end
        endcase
    end

    assign phase   = phase_reg;
    assign halted  = (state_reg == HALTED);
    assign bus_err = (state_reg == ERROR);
    assign stall   = stall_next;

    verisc_decode u_decode (
        .run    (state_reg == RUN),
        .phase  (phase_reg),
        .opcode (opcode),
        .zero   (zero),
        .sel    (sel),
        .rd     (rd),
        .ld_ir  (ld_ir),
        .halt   (halt),
        .inc_pc (inc_pc),
        .ld_ac  (ld_ac),
        .ld_pc  (ld_pc),
        .wr     (wr),
        .data_e (data_e)
    );

endmodule

// File: tb/tb_verisc_seq_ctrl.sv
// Directed self-checking bench for verisc_seq_ctrl (built with WAIT_TMO=4).
module tb_verisc_seq_ctrl;
    import verisc_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] opcode = ADD;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       resume = 1'b0;
`ifdef VERISC_SEQ_CTRL_STEP_EN
    logic       step_mode = 1'b0;
`endif
    logic sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e;
    logic [2:0] phase;
    logic halted, bus_err, stall;
    logic [8:0] st;

    int checks = 0;
    int failures = 0;

    // {sel,rd,ld_ir,halt,inc_pc,ld_ac,ld_pc,wr,data_e} for ADD, phases 0..7
    localparam logic [8:0] ADD_EXP [8] = '{
        9'b100000000, 9'b110000000, 9'b111000000, 9'b111000000,
        9'b000010000, 9'b010000000, 9'b010000000, 9'b010001000
    };

    assign st = {sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e};

    verisc_seq_ctrl #(.WAIT_TMO(4), .TMO_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .opcode    (opcode),
        .zero      (zero),
        .mem_ready (mem_ready),
        .resume    (resume),
`ifdef VERISC_SEQ_CTRL_STEP_EN
        .step_mode (step_mode),
`endif
        .sel       (sel),
        .rd        (rd),
        .ld_ir     (ld_ir),
        .halt      (halt),
        .inc_pc    (inc_pc),
        .ld_ac     (ld_ac),
        .ld_pc     (ld_pc),
        .wr        (wr),
        .data_e    (data_e),
        .phase     (phase),
        .halted    (halted),
        .bus_err   (bus_err),
        .stall     (stall)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic goto_phase(input logic [2:0] p);
        int n = 0;
        while (phase !== p && n < 20) begin
            tick();
            n++;
        end
        #1;
        checks++;
        if (phase !== p) begin
            failures++;
            $display("FAIL goto_phase: phase=%0d want %0d", phase, p);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        opcode = ADD;
        mem_ready = 1'b1;
        #3;
        checks++;
        if (phase !== 3'd0 || st !== 9'b100000000 || halted !== 1'b0 || bus_err !== 1'b0 || stall !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: phase=%0d st=%b halted=%b bus_err=%b stall=%b want 0 100000000 0 0 0",
                     phase, st, halted, bus_err, stall);
        end
        tick();
        rst_n = 1'b1;
        #1;
        $display("reset: phase=%0d st=%b", phase, st);
    endtask

    task automatic test_add();
        opcode = ADD;
        mem_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (phase !== 3'(i) || st !== ADD_EXP[i]) begin
                failures++;
                $display("FAIL add_phase%0d: phase=%0d st=%b want phase=%0d st=%b", i, phase, st, i, ADD_EXP[i]);
            end
            $display("add: phase=%0d st=%b", phase, st);
            tick();
        end
        checks++;
        if (phase !== 3'd0) begin
            failures++;
            $display("FAIL add_wrap: phase=%0d want 0", phase);
        end
    endtask

    task automatic test_lda_wait();
        int cyc = 0;
        int nstall = 0;
        opcode = LDA;
        do begin
            mem_ready = !(phase == OP_FETCH && nstall < 3);
            #1;
            checks++;
            if (!mem_ready) begin
                nstall++;
                if (stall !== 1'b1 || phase !== 3'd5 || st !== 9'b010000000) begin
                    failures++;
                    $display("FAIL lda_stall: stall=%b phase=%0d st=%b want 1 5 010000000", stall, phase, st);
                end
            end else if (stall !== 1'b0) begin
                failures++;
                $display("FAIL lda_nostall: stall=%b want 0 at phase %0d", stall, phase);
            end
            tick();
            cyc++;
        end while (phase !== 3'd0 && cyc < 30);
        mem_ready = 1'b1;
        checks++;
        if (cyc !== 11) begin
            failures++;
            $display("FAIL lda_cycles: cycles=%0d want 11", cyc);
        end
        $display("lda_wait: cycles=%0d", cyc);
    endtask

    task automatic test_skz();
        logic [7:0] inc_m;
        opcode = SKZ;
        for (int z = 1; z >= 0; z--) begin
            zero = z[0];
            inc_m = (z == 1) ? 8'b0101_0000 : 8'b0001_0000;
            for (int p = 0; p < 8; p++) begin
                checks++;
                if (phase !== 3'(p) || inc_pc !== inc_m[p] || ld_pc !== 1'b0) begin
                    failures++;
                    $display("FAIL skz_z%0d_p%0d: phase=%0d inc_pc=%b ld_pc=%b want %0d %b 0",
                             z, p, phase, inc_pc, ld_pc, p, inc_m[p]);
                end
                tick();
            end
            $display("skz: zero=%0d done", z);
        end
        zero = 1'b0;
    endtask

    task automatic test_jmp();
        logic [7:0] ld_m;
        ld_m = 8'b1100_0000;
        opcode = JMP;
        zero = 1'b1;
        for (int p = 0; p < 8; p++) begin
            checks++;
            if (phase !== 3'(p) || ld_pc !== ld_m[p] || inc_pc !== (p == 4)) begin
                failures++;
                $display("FAIL jmp_p%0d: phase=%0d ld_pc=%b inc_pc=%b want %0d %b %b",
                         p, phase, ld_pc, inc_pc, p, ld_m[p], (p == 4));
            end
            tick();
        end
        zero = 1'b0;
        $display("jmp: done");
    endtask

    task automatic test_halt();
        opcode = HLT;
        goto_phase(3'd4);
        checks++;
        if (st !== 9'b000110000) begin
            failures++;
            $display("FAIL halt_strobe: st=%b want 000110000", st);
        end
        tick();
        checks++;
        if (halted !== 1'b1 || phase !== 3'd0 || st !== 9'b000000000) begin
            failures++;
            $display("FAIL halt_enter: halted=%b phase=%0d st=%b want 1 0 000000000", halted, phase, st);
        end
        tick();
        tick();
        resume = 1'b1;
        #1;
        checks++;
        if (halted !== 1'b1 || phase !== 3'd0) begin
            failures++;
            $display("FAIL halt_hold: halted=%b phase=%0d want 1 0", halted, phase);
        end
        tick();
        resume = 1'b0;
        opcode = ADD;
        #1;
        checks++;
        if (halted !== 1'b0 || phase !== 3'd0 || st !== 9'b100000000) begin
            failures++;
            $display("FAIL halt_resume: halted=%b phase=%0d st=%b want 0 0 100000000", halted, phase, st);
        end
        tick();
        checks++;
        if (phase !== 3'd1) begin
            failures++;
            $display("FAIL halt_rerun: phase=%0d want 1", phase);
        end
        $display("halt: resumed phase=%0d", phase);
    endtask

    task automatic test_tmo_boundary();
        opcode = ADD;
        goto_phase(3'd1);
        mem_ready = 1'b0;
        repeat (3) tick();
        mem_ready = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b0 || bus_err !== 1'b0) begin
            failures++;
            $display("FAIL tmo_ready_wins_pre: stall=%b bus_err=%b want 0 0", stall, bus_err);
        end
        tick();
        checks++;
        if (phase !== 3'd2 || bus_err !== 1'b0) begin
            failures++;
            $display("FAIL tmo_ready_wins: phase=%0d bus_err=%b want 2 0", phase, bus_err);
        end
        $display("tmo_boundary: phase=%0d bus_err=%b", phase, bus_err);
    endtask

    task automatic test_timeout();
        opcode = ADD;
        goto_phase(3'd1);
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (bus_err !== 1'b0 || stall !== 1'b1 || phase !== 3'd1) begin
                failures++;
                $display("FAIL tmo_stall%0d: bus_err=%b stall=%b phase=%0d want 0 1 1", i, bus_err, stall, phase);
            end
            tick();
        end
        checks++;
        if (bus_err !== 1'b1 || phase !== 3'd1 || st !== 9'b000000000 || stall !== 1'b0) begin
            failures++;
            $display("FAIL tmo_error: bus_err=%b phase=%0d st=%b stall=%b want 1 1 000000000 0",
                     bus_err, phase, st, stall);
        end
        resume = 1'b1;
        tick();
        resume = 1'b0;
        mem_ready = 1'b1;
        tick();
        checks++;
        if (bus_err !== 1'b1 || phase !== 3'd1 || halted !== 1'b0 || st !== 9'b000000000) begin
            failures++;
            $display("FAIL tmo_sticky: bus_err=%b phase=%0d halted=%b st=%b want 1 1 0 000000000",
                     bus_err, phase, halted, st);
        end
        $display("timeout: bus_err=%b phase=%0d", bus_err, phase);
    endtask

    task automatic test_reset_mid_stall();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        opcode = STO;
        mem_ready = 1'b1;
        goto_phase(3'd7);
        mem_ready = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b1 || st !== 9'b000000011) begin
            failures++;
            $display("FAIL sto_stall: stall=%b st=%b want 1 000000011", stall, st);
        end
        tick();
        checks++;
        if (phase !== 3'd7 || wr !== 1'b1) begin
            failures++;
            $display("FAIL sto_hold: phase=%0d wr=%b want 7 1", phase, wr);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (phase !== 3'd0 || wr !== 1'b0 || stall !== 1'b0 || st !== 9'b100000000 || bus_err !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_stall: phase=%0d wr=%b stall=%b st=%b bus_err=%b want 0 0 0 100000000 0",
                     phase, wr, stall, st, bus_err);
        end
        #1;
        rst_n = 1'b1;
        mem_ready = 1'b1;
        opcode = ADD;
        $display("reset_mid_stall: phase=%0d", phase);
    endtask

`ifdef VERISC_SEQ_CTRL_STEP_EN
    task automatic test_step();
        step_mode = 1'b1;
        opcode = ADD;
        goto_phase(3'd7);
        checks++;
        if (halted !== 1'b0 || halt !== 1'b0) begin
            failures++;
            $display("FAIL step_pre: halted=%b halt=%b want 0 0", halted, halt);
        end
        tick();
        checks++;
        if (halted !== 1'b1 || phase !== 3'd0 || halt !== 1'b0) begin
            failures++;
            $display("FAIL step_stop: halted=%b phase=%0d halt=%b want 1 0 0", halted, phase, halt);
        end
        resume = 1'b1;
        tick();
        resume = 1'b0;
        #1;
        checks++;
        if (halted !== 1'b0 || phase !== 3'd0) begin
            failures++;
            $display("FAIL step_resume: halted=%b phase=%0d want 0 0", halted, phase);
        end
        step_mode = 1'b0;
        $display("step: halted=%b phase=%0d", halted, phase);
    endtask
`endif

    initial begin
        test_reset();
        test_add();
        test_lda_wait();
        test_skz();
        test_jmp();
        test_halt();
        test_tmo_boundary();
        test_timeout();
        test_reset_mid_stall();
`ifdef VERISC_SEQ_CTRL_STEP_EN
        test_step();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/verisc_seq_ctrl.md
Name: verisc_seq_ctrl

Overview:
- Next-generation VeriRISC controller with its own 8-phase sequencer; no external phase counter needed.
- Decodes the 3-bit opcode into the same nine datapath strobes as the previous generation.
- Adds memory wait-states via mem_ready, a wait timeout with a sticky error, and a HALTED state left by a resume pulse.
- Sits between instruction register, PC, accumulator and memory bus in the VeriRISC top.

Parameters:
- WAIT_TMO, 15: consecutive stalled cycles that trigger the bus error; 1..2^TMO_W-1.
- TMO_W, 4: wait-counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  3  IR opcode: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
- zero  in  1  accumulator-zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- resume  in  1  single-cycle pulse; leaves HALTED.
- sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e  out  1 each  datapath strobes.
- phase  out  3  current phase.
- halted  out  1  HALTED state.
- bus_err  out  1  sticky timeout error.
- stall  out  1  phase held this cycle due to wait.

Behaviour:
- Decode groups: ALUOP = ADD|AND|XOR|LDA; HALT = HLT; SKZ; STO; JMP.
- Strobes are combinational from (phase, opcode, zero) when the run state is RUN, per phase:
  - 0 INST_ADDR: sel.
  - 1 INST_FETCH: sel, rd.
  - 2 INST_LOAD: sel, rd, ld_ir.
  - 3 IDLE: sel, rd, ld_ir.
  - 4 OP_ADDR: inc_pc; halt = HALT.
  - 5 OP_FETCH: rd = ALUOP.
  - 6 ALU_OP: rd = ALUOP; inc_pc = SKZ & zero; ld_pc = JMP; data_e = STO.
  - 7 STORE: rd = ALUOP; ld_ac = ALUOP; ld_pc = JMP; wr = STO; data_e = STO.
- Run state machine, registered: RUN, HALTED, ERROR.
- RUN:
  - phase increments every cycle, 7 wraps to 0, unless stalled.
  - Wait phases are 1, and 5 when ALUOP, and 7 when STO.
  - In a wait phase with mem_ready=0: phase holds, stall=1, wait counter increments.
  - Counter clears whenever phase advances.
  - Strobes are re-driven with identical values while stalled.
  - Stalled cycle with counter == WAIT_TMO-1 goes to ERROR.
- Phase 4 with HALT: halt and inc_pc asserted for that one cycle; next state HALTED, phase set to 0.
- HALTED:
  - All strobes 0; halted=1; phase holds 0.
  - resume=1 returns to RUN with phase 0 on the next cycle.
  - resume is ignored in RUN and ERROR.
- ERROR:
  - All strobes 0; bus_err=1 sticky; phase frozen at the faulting value.
  - Exit only via reset.
- Simultaneous events:
  - Timeout and mem_ready=1 in the same cycle: mem_ready wins, no error.
  - A halt cannot coincide with a stall because phase 4 is never a wait phase.
- Reset (asynchronous, any time, including mid-stall):
  - phase=0, state RUN, counter=0, bus_err=0, halted=0, stall=0.
  - Strobes then decode phase 0: sel=1, all other strobes 0.
- zero is sampled combinationally only in phase 6.

Optional Feature:
- Macro VERISC_SEQ_CTRL_STEP_EN.
- When defined:
  - Adds input step_mode.
  - With step_mode=1, RUN enters HALTED at every phase 7→0 transition, so exactly one instruction executes per resume.
  - halt strobe stays 0 for these stops; only halted=1.
- When undefined: no step_mode port; behaviour exactly as above.

Decomposition:
- Package verisc_pkg:
  - Opcode localparams HLT..JMP.
  - Phase localparams INST_ADDR..STORE.
  - Run-state encoding RUN/HALTED/ERROR.
- One natural sub-module: verisc_decode, the purely combinational opcode/phase → strobe table.
- verisc_seq_ctrl holds the phase counter, wait counter and run state machine.

Test Plan:
- Reset then opcode=ADD, mem_ready=1 → phases 0..7 in 8 cycles; rd in 1,2,3,5,6,7; ld_ac only at phase 7; inc_pc only at 4.
- opcode=LDA, mem_ready=0 for 3 cycles at phase 5 → phase held at 5 for 3 extra cycles, stall=1; then 6; total 11 cycles per instruction.
- WAIT_TMO=4, mem_ready stuck 0 at phase 1 → bus_err=1 after 4 stalled cycles; phase stays 1; strobes 0; resume ignored.
- opcode=HLT → halt=1 and inc_pc=1 at phase 4, then halted=1, phase=0; resume pulse → next cycle RUN, phase 0, sel=1.
- opcode=SKZ with zero=1 → inc_pc at phases 4 and 6; with zero=0, phase 4 only. opcode=JMP → ld_pc at phases 6 and 7.
- rst_n low mid-stall at phase 7 (STO, wr=1) → immediately phase=0, wr=0, stall=0, sel=1. STEP_EN build with step_mode=1 → halted after each phase 7.
